// File: rtl/cell_renderer.sv
// Renders a COLS x ROWS cell grid onto 640x480 VGA from a prefetched one-row line buffer.
// Optional macro GRIDLINE_EN draws 3'b001 gridlines on the first pixel/line of every cell.
module cell_renderer #(
  parameter int         COLS     = 64,
  parameter int         ROWS     = 48,
  parameter int         CELL_PX  = 10,
  parameter logic [2:0] LIVE_RGB = 3'b010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      CounterX,
  input  logic [9:0]      CounterY,
  input  logic            inDisplayArea,
  output logic            row_req,
  output logic [5:0]      row_addr,
  input  logic [COLS-1:0] row_data,
  input  logic            row_valid,
  output logic            vga_r,
  output logic            vga_g,
  output logic            vga_b,
  output logic            underrun
);
  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [5:0]    ROW_LAST = 6'(ROWS - 1);

  logic [COLS-1:0] r_buf;
  logic            r_req;
  logic [5:0]      r_addr;
  logic            r_under;
  logic [5:0]      r_row;
  logic [SW-1:0]   r_subrow;
  logic [SW-1:0]   r_subpx;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   r_s1_col;
  logic            r_s1_de;
  logic [2:0]      r_vga;

  logic [SW-1:0]   w_subpx;
  logic [CW-1:0]   w_col;
  logic [5:0]      w_row_inc;
  logic [2:0]      w_colour;

  // Counters are forced to zero combinationally on CounterX==0 so the first pixel is column 0.
  assign w_subpx   = (CounterX == 10'd0) ? '0 : r_subpx;
  assign w_col     = (CounterX == 10'd0) ? '0 : r_col;
  assign w_row_inc = (r_row == ROW_LAST) ? 6'd0 : r_row + 6'd1;

`ifdef GRIDLINE_EN
  logic r_s1_grid;

  always_ff @(posedge clk) begin
    if (!reset) r_s1_grid <= 1'b0;
    else        r_s1_grid <= (w_subpx == '0) || (r_subrow == '0);
  end
`endif

  always_comb begin
    w_colour = 3'b000;
    if (r_s1_de) begin
`ifdef GRIDLINE_EN
      if (r_s1_grid)               w_colour = 3'b001;
      else if (r_buf[r_s1_col])    w_colour = LIVE_RGB;
`else
      if (r_buf[r_s1_col])         w_colour = LIVE_RGB;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf    <= '0;
      r_req    <= 1'b0;
      r_addr   <= 6'd0;
      r_under  <= 1'b0;
      r_row    <= 6'd0;
      r_subrow <= '0;
      r_subpx  <= '0;
      r_col    <= '0;
      r_s1_col <= '0;
      r_s1_de  <= 1'b0;
      r_vga    <= 3'b000;
    end else begin
      r_subpx <= (w_subpx == SUB_LAST) ? '0 : w_subpx + 1'b1;
      if (w_subpx == SUB_LAST) r_col <= (w_col == COL_LAST) ? '0 : w_col + 1'b1;
      else                     r_col <= w_col;

      r_s1_col <= w_col;
      r_s1_de  <= inDisplayArea;
      r_vga    <= w_colour;

      // A late row arriving exactly at CounterX==0 still counts as on time.
      if (r_req && row_valid) begin
        r_buf <= row_data;
        r_req <= 1'b0;
      end else if (r_req && CounterX == 10'd0) begin
        r_under <= 1'b1;
        r_req   <= 1'b0;
      end

      if (CounterX == 10'd640) begin
        if (CounterY == 10'd524) begin
          r_row    <= 6'd0;
          r_subrow <= '0;
          r_req    <= 1'b1;
          r_addr   <= 6'd0;
        end else if (CounterY < 10'd479) begin
          if (r_subrow == SUB_LAST) begin
            r_subrow <= '0;
            r_row    <= w_row_inc;
            r_req    <= 1'b1;
            r_addr   <= w_row_inc;
          end else begin
            r_subrow <= r_subrow + 1'b1;
          end
        end
      end
    end
  end

  assign row_req  = r_req;
  assign row_addr = r_addr;
  assign underrun = r_under;
  assign vga_r    = r_vga[2];
  assign vga_g    = r_vga[1];
  assign vga_b    = r_vga[0];
endmodule

// File: tb/tb_cell_renderer.sv
// Self-checking bench for cell_renderer: line-level reference model plus directed literal checks.
// Honours GRIDLINE_EN the same way as the design.
module tb_cell_renderer;
  localparam int         COLS    = 64;
  localparam int         ROWS    = 48;
  localparam int         CELL_PX = 10;
  localparam logic [2:0] LIVE    = 3'b010;
`ifdef GRIDLINE_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif
  localparam logic [COLS-1:0] ONES = '1;

  logic            clk = 1'b0;
  logic            reset;
  logic [9:0]      CounterX;
  logic [9:0]      CounterY;
  logic            inDisplayArea;
  logic            row_req;
  logic [5:0]      row_addr;
  logic [COLS-1:0] row_data;
  logic            row_valid;
  logic            vga_r, vga_g, vga_b;
  logic            underrun;

  cell_renderer #(.COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL_PX), .LIVE_RGB(LIVE)) dut (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .row_req(row_req), .row_addr(row_addr),
    .row_data(row_data), .row_valid(row_valid), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
  endtask

  // Reference model: a line is the line number, a cell is x/CELL_PX and line/CELL_PX.
  logic            m_req, m_under;
  logic [5:0]      m_addr;
  logic [COLS-1:0] m_buf;
  logic [2:0]      m_s1, m_vga, m_c;
  int              m_line, m_next;

  function automatic logic [2:0] px_colour(input int x, input bit de, input logic [COLS-1:0] b,
                                           input int ln);
    if (!de) return 3'b000;
    if (G && ((x % CELL_PX) == 0 || (ln % CELL_PX) == 0)) return 3'b001;
    if (x / CELL_PX >= COLS) return 3'b000;
    return b[x / CELL_PX] ? LIVE : 3'b000;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_req = 1'b0; m_under = 1'b0; m_addr = 6'd0; m_buf = '0;
      m_s1 = 3'b000; m_vga = 3'b000; m_line = 0;
    end else begin
      if (m_req && row_valid) begin
        m_buf = row_data; m_req = 1'b0;
      end else if (m_req && CounterX == 10'd0) begin
        m_under = 1'b1; m_req = 1'b0;
      end
      m_c   = px_colour(int'(CounterX), inDisplayArea, m_buf, m_line);
      m_vga = m_s1;
      m_s1  = m_c;
      if (CounterX == 10'd640) begin
        if (CounterY == 10'd524)     m_next = 0;
        else if (CounterY < 10'd479) m_next = int'(CounterY) + 1;
        else                         m_next = -1;
        if (m_next >= 0) begin
          m_line = m_next;
          if (m_next % CELL_PX == 0) begin
            m_req  = 1'b1;
            m_addr = 6'(m_next / CELL_PX);
          end
        end
      end
    end
    #1;
    check("vga", {61'd0, vga_r, vga_g, vga_b}, {61'd0, m_vga});
    check("row_req", {63'd0, row_req}, {63'd0, m_req});
    check("row_addr", {58'd0, row_addr}, {58'd0, m_addr});
    check("underrun", {63'd0, underrun}, {63'd0, m_under});
  end

  // Stimulus helpers; outputs read at the negedge after each active edge.
  logic [2:0] lastpx [0:127];
  logic       req_issue, req_after_valid, under_x0, req_x0;
  logic [5:0] addr_issue;

  task automatic step(input int x, input int y, input bit de, input bit v, input logic [COLS-1:0] d);
    CounterX = 10'(x); CounterY = 10'(y); inDisplayArea = de; row_valid = v; row_data = d;
    @(negedge clk);
  endtask

  task automatic line(input int y, input int npx, input bit de, input int vpos,
                      input logic [COLS-1:0] d);
    for (int x = 0; x < npx; x++) begin
      step(x, y, de, 1'b0, '0);
      if (x > 0) lastpx[x-1] = {vga_r, vga_g, vga_b};
      if (x == 0) begin under_x0 = underrun; req_x0 = row_req; end
    end
    for (int i = 0; i < 8; i++) begin
      step(640 + i, y, 1'b0, (i == vpos), (i == vpos) ? d : '0);
      if (i == 0) begin
        if (npx > 0) lastpx[npx-1] = {vga_r, vga_g, vga_b};
        req_issue = row_req; addr_issue = row_addr;
      end
      if (i == vpos) req_after_valid = row_req;
    end
    $display("line y=%0d px=%0d de=%0d valid_at=%0d row_req=%0d underrun=%0d",
             y, npx, de, vpos, row_req, underrun);
  endtask

  initial begin
    reset = 1'b0; CounterX = '0; CounterY = '0; inDisplayArea = 1'b0;
    row_valid = 1'b0; row_data = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, '0);
    check("rst_vga", {vga_r, vga_g, vga_b}, 3'b000);
    check("rst_req", row_req, 1'b0);
    check("rst_addr", row_addr, 6'd0);
    check("rst_under", underrun, 1'b0);
    reset = 1'b1;

    line(524, 0, 1'b0, 5, 64'hA5);
    check("fetch524_req", req_issue, 1'b1);
    check("fetch524_addr", addr_issue, 6'd0);
    check("valid_drops_req", req_after_valid, 1'b0);

    line(0, 80, 1'b1, -1, '0);
    check("l0_x0", lastpx[0], G ? 3'b001 : 3'b010);
    check("l0_x9", lastpx[9], G ? 3'b001 : 3'b010);
    check("l0_x10", lastpx[10], G ? 3'b001 : 3'b000);
    check("l0_x20", lastpx[20], G ? 3'b001 : 3'b010);

    for (int y = 1; y <= 8; y++) line(y, 12, 1'b1, -1, '0);
    line(9, 12, 1'b1, 3, ONES);
    check("fetch9_req", req_issue, 1'b1);
    check("fetch9_addr", addr_issue, 6'd1);
    line(10, 25, 1'b1, -1, '0);
    check("nofetch10", req_issue, 1'b0);
    line(11, 25, 1'b1, -1, '0);
    check("l11_x0", lastpx[0], G ? 3'b001 : 3'b010);
    check("l11_x1", lastpx[1], 3'b010);
    line(12, 25, 1'b0, -1, '0);
    check("blank_de0", lastpx[5], 3'b000);

    for (int y = 13; y <= 18; y++) line(y, 12, 1'b1, -1, '0);
    line(19, 12, 1'b1, -1, '0);
    check("fetch19_addr", addr_issue, 6'd2);
    line(20, 25, 1'b1, -1, '0);
    check("underrun_set", under_x0, 1'b1);
    check("underrun_drop", req_x0, 1'b0);
    line(21, 25, 1'b1, 2, '0);
    line(22, 25, 1'b1, -1, '0);
    check("stale_buf", lastpx[15], 3'b010);
    check("underrun_sticky", underrun, 1'b1);

    for (int y = 23; y <= 28; y++) line(y, 12, 1'b1, -1, '0);
    line(29, 12, 1'b1, 4, {16{4'b0011}});
    for (int y = 30; y <= 38; y++) line(y, 25, 1'b1, -1, '0);
    line(39, 0, 1'b0, -1, '0);
    reset = 1'b0;
    step(641, 39, 1'b0, 1'b1, ONES);
    step(642, 39, 1'b0, 1'b1, ONES);
    reset = 1'b1;
    check("midrst_req", row_req, 1'b0);
    check("midrst_vga", {vga_r, vga_g, vga_b}, 3'b000);
    check("midrst_under", underrun, 1'b0);

    line(40, 25, 1'b1, -1, '0);
    check("post_rst_black", lastpx[0], G ? 3'b001 : 3'b000);
    line(500, 0, 1'b0, -1, '0);
    check("hold_nofetch", req_issue, 1'b0);
    line(524, 0, 1'b0, 2, 64'h3);
    line(0, 25, 1'b1, -1, '0);
    check("refetch_x12", lastpx[12], G ? 3'b001 : 3'b010);
    check("refetch_x22", lastpx[22], G ? 3'b001 : 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cell_renderer.md
CELL_RENDERER -- requirements
Module: cell_renderer

Interface
REQ-001 Parameter COLS, default 64, grid columns; one row_data bit per column, bit j = column j.
REQ-002 Parameter ROWS, default 48, grid rows.
REQ-003 Parameter CELL_PX, default 10, square cell edge in pixels (COLS*CELL_PX=640, ROWS*CELL_PX=480).
REQ-004 Parameter LIVE_RGB, default 3'b010, {r,g,b} colour for a live cell; dead cells are 3'b000.
REQ-005 clk  in  1  pixel clock, same clock as the hvsync generator.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 CounterX  in  10  current horizontal pixel count, 0..799.
REQ-008 CounterY  in  10  current vertical line count, 0..524.
REQ-009 inDisplayArea  in  1  high while the pixel is visible.
REQ-010 row_req  out  1  request for one grid row; held high until accepted.
REQ-011 row_addr  out  6  requested row index, 0..ROWS-1, stable while row_req is high.
REQ-012 row_data  in  COLS  row contents, sampled in the cycle row_valid is high.
REQ-013 row_valid  in  1  one-cycle acceptance strobe from the grid owner.
REQ-014 vga_r, vga_g, vga_b  out  1 each  registered pixel colour.
REQ-015 underrun  out  1  sticky flag: a row fetch missed its deadline.

Function
REQ-016 The block SHALL hold a COLS-bit line buffer, and SHALL drive every pixel from it and never from row_data directly.
REQ-017 At CounterX==640 the block SHALL compute the cell row of the next line. If CounterY==524, next row=0 and sub-row=0. If CounterY<479, sub-row increments; on reaching CELL_PX it wraps to 0 and the row increments. Otherwise it holds.
REQ-018 A fetch SHALL be issued at CounterX==640 only when the next line starts a new cell row (sub-row becomes 0): row_req=1 and row_addr=next row.
REQ-019 row_req SHALL stay high until row_valid; in that cycle row_data loads the line buffer and row_req drops on the following edge.
REQ-020 row_valid SHALL be ignored while row_req is low.
REQ-021 If row_req is still high when CounterX==0, the block SHALL set underrun, drop row_req, and render the line from the stale buffer.
REQ-022 A fetch issued while an earlier request is pending SHALL replace the earlier row_addr; only one request is ever outstanding.
REQ-023 Horizontally, a sub-pixel counter 0..CELL_PX-1 and a column counter 0..COLS-1 SHALL reset at CounterX==0 and advance each cycle; no divider is used.
REQ-024 The pixel path SHALL be a 2-stage pipeline: stage 1 registers the column index and inDisplayArea; stage 2 registers the colour. Latency from CounterX/inDisplayArea to vga_* is 2 clk.
REQ-025 Colour rules: live bit -> LIVE_RGB; dead bit -> 000; delayed inDisplayArea low -> 000 regardless of cell state.
REQ-026 The block SHALL not alter sync timing; the integrator delays the sync outputs by 2 clk.

Reset
REQ-027 With reset low at a clk edge, the block SHALL clear vga_r/g/b, row_req, underrun, the line buffer, all counters and the pipeline; row_addr=0.
REQ-028 Reset SHALL abort any pending request with no row_valid handshake. After reset the first fetch occurs at the next qualifying CounterX==640, and lines before it render black.
REQ-029 Only reset SHALL clear underrun.

Configuration
REQ-030 Macro GRIDLINE_EN. When defined, a visible pixel whose sub-pixel or sub-row counter is 0 SHALL output 3'b001, overriding cell colour; when undefined, no gridline logic exists and REQ-025 alone applies.

Verification
REQ-031 Reset low for 2 clk mid-fetch -> row_req=0, vga=000 and underrun=0 next cycle; no buffer load.
REQ-032 CounterY=524, CounterX=640 -> row_req=1 and row_addr=0. row_valid 5 clk later with row_data bit0=1 -> pixels X=0..9 of line 0 are 010 and X=10 is 000, each 2 clk after CounterX.
REQ-033 CounterY=9, CounterX=640 -> fetch row_addr=1. CounterY=10, CounterX=640 -> no fetch.
REQ-034 Withhold row_valid past CounterX=0 -> underrun=1 and sticky, row_req=0, line rendered from the old buffer.
REQ-035 inDisplayArea=0 with an all-ones buffer -> vga=000 at 2-clk latency.
REQ-036 GRIDLINE_EN defined, all-ones buffer -> X=0,10,20 output 001, X=1 outputs 010; undefined -> X=0 outputs 010.
